// File: rtl/mod_writeback_rf_if.sv
// EX/WB bundle and store-acknowledge handshake between execute, writeback and memory.
// The master side presents bundles and acknowledges stores; the slave side is the writeback stage.
interface mod_writeback_rf_if #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 64
);
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_dst0_en;
    logic [IDX_W-1:0]  wb_dst0_idx;
    logic [DATA_W-1:0] wb_dst0_data;
    logic              wb_dst1_en;
    logic [IDX_W-1:0]  wb_dst1_idx;
    logic [DATA_W-1:0] wb_dst1_data;
    logic [1:0]        wb_sp_adj;
    logic              wb_store;
    logic              wb_end;
    logic              store_ack;
    logic              store_req;

    modport master (
        output wb_valid, wb_dst0_en, wb_dst0_idx, wb_dst0_data,
               wb_dst1_en, wb_dst1_idx, wb_dst1_data, wb_sp_adj,
               wb_store, wb_end, store_ack,
        input  wb_ready, store_req
    );

    modport slave (
        input  wb_valid, wb_dst0_en, wb_dst0_idx, wb_dst0_data,
               wb_dst1_en, wb_dst1_idx, wb_dst1_data, wb_sp_adj,
               wb_store, wb_end, store_ack,
        output wb_ready, store_req
    );
endinterface

// File: rtl/mod_writeback_rf.sv
// Writeback stage owning the architectural register file: two write ports, SP adjust, store wait, halt.
// Optional same-cycle read bypass (byp_idx/byp_data) is enabled by defining WB_BYPASS_EN.
module mod_writeback_rf #(
    parameter int                NUM_REGS = 16,
    parameter int                DATA_W   = 64,
    parameter int                IDX_W    = 4,
    parameter int                SP_IDX   = 4,
    parameter int                SP_STEP  = 8,
    parameter logic [DATA_W-1:0] SP_RESET = 64'h0000_0000_7FFF_F000,
    parameter int                CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    mod_writeback_rf_if.slave          wb,
`ifdef WB_BYPASS_EN
    input  logic [IDX_W-1:0]           byp_idx,
    output logic [DATA_W-1:0]          byp_data,
`endif
    output logic [NUM_REGS*DATA_W-1:0] regfile,
    output logic                       halted,
    output logic [CNT_W-1:0]           retire_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STORE_WAIT,
        ST_HALT
    } state_e;

    state_e            state_q, state_d;
    logic              end_pend_q, end_pend_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic              ready;
    logic              accept;

    assign ready        = (state_q == ST_RUN);
    assign accept       = wb.wb_valid && ready;
    assign wb.wb_ready  = ready;
    assign wb.store_req = (state_q == ST_STORE_WAIT);
    assign halted       = (state_q == ST_HALT);
    assign retire_cnt   = retire_cnt_q;

    // NOTE: every variable gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        end_pend_d = end_pend_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (wb.wb_store) begin
                        state_d    = ST_STORE_WAIT;
                        end_pend_d = wb.wb_end;
                    end else if (wb.wb_end) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_STORE_WAIT: begin
                if (wb.store_ack) begin
                    state_d = end_pend_q ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Later assignments win: SP adjust, then dst1, then dst0.
    always_comb begin
        rf_d         = rf_q;
        retire_cnt_d = retire_cnt_q;
        if (accept) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
            case (wb.wb_sp_adj)
                2'b01:   rf_d[SP_IDX] = rf_q[SP_IDX] + DATA_W'(SP_STEP);
                2'b10:   rf_d[SP_IDX] = rf_q[SP_IDX] - DATA_W'(SP_STEP);
                default: ;
            endcase
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb.wb_dst1_en && wb.wb_dst1_idx == IDX_W'(i)) rf_d[i] = wb.wb_dst1_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb.wb_dst0_en && wb.wb_dst0_idx == IDX_W'(i)) rf_d[i] = wb.wb_dst0_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            end_pend_q   <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            end_pend_q   <= end_pend_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // NOTE: the register array is reset because its contents are architectural state with defined reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    always_comb begin
        regfile = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regfile[i*DATA_W +: DATA_W] = rf_q[i];
        end
    end

`ifdef WB_BYPASS_EN
    // rf_d already holds the post-accept value, including port priority.
    always_comb begin
        byp_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (byp_idx == IDX_W'(i)) byp_data = rf_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_mod_writeback_rf.sv
// Directed self-checking bench for mod_writeback_rf with hand-computed expectations.
module tb_mod_writeback_rf;

    localparam logic [63:0] SP_RST = 64'h0000_0000_7FFF_F000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [16*64-1:0]  regfile;
    logic              halted;
    logic [31:0]       retire_cnt;
    int                checks = 0;
    int                errors = 0;
`ifdef WB_BYPASS_EN
    logic [3:0]        byp_idx = '0;
    logic [63:0]       byp_data;
`endif

    mod_writeback_rf_if #(.IDX_W(4), .DATA_W(64)) wbif ();

    mod_writeback_rf dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wbif),
`ifdef WB_BYPASS_EN
        .byp_idx    (byp_idx),
        .byp_data   (byp_data),
`endif
        .regfile    (regfile),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf(input int i);
        return regfile[i*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wbif.wb_valid     = 1'b0;
        wbif.wb_dst0_en   = 1'b0;
        wbif.wb_dst0_idx  = '0;
        wbif.wb_dst0_data = '0;
        wbif.wb_dst1_en   = 1'b0;
        wbif.wb_dst1_idx  = '0;
        wbif.wb_dst1_data = '0;
        wbif.wb_sp_adj    = 2'b00;
        wbif.wb_store     = 1'b0;
        wbif.wb_end       = 1'b0;
        wbif.store_ack    = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rf(i) !== ((i == 4) ? SP_RST : 64'd0)) begin
                errors++;
                $display("FAIL reset_rf[%0d]: got %h expected %h", i, rf(i), (i == 4) ? SP_RST : 64'd0);
            end
        end
        checks++;
        if (wbif.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wbif.wb_ready); end
        checks++;
        if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", retire_cnt); end
        checks++;
        if (wbif.store_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got store_req=%b halted=%b expected 0 0", wbif.store_req, halted);
        end
    endtask

    task automatic test_dual_write();
        apply_reset();
        wbif.wb_valid = 1'b1;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd0; wbif.wb_dst0_data = 64'd5;
        wbif.wb_dst1_en = 1'b1; wbif.wb_dst1_idx = 4'd2; wbif.wb_dst1_data = 64'd7;
        tick();
        clear_inputs();
        checks++;
        if (rf(0) !== 64'd5) begin errors++; $display("FAIL dual_rf0: got %h expected 5", rf(0)); end
        checks++;
        if (rf(2) !== 64'd7) begin errors++; $display("FAIL dual_rf2: got %h expected 7", rf(2)); end
        checks++;
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL dual_cnt: got %0d expected 1", retire_cnt); end
        tick();
        checks++;
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL idle_cnt: got %0d expected 1", retire_cnt); end
    endtask

    task automatic test_priority();
        apply_reset();
        // SP +8 overridden by dst0 on SP; dst1 lands elsewhere.
        wbif.wb_valid = 1'b1; wbif.wb_sp_adj = 2'b01;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd4; wbif.wb_dst0_data = 64'h1234;
        wbif.wb_dst1_en = 1'b1; wbif.wb_dst1_idx = 4'd6; wbif.wb_dst1_data = 64'h55;
        tick();
        checks++;
        if (rf(4) !== 64'h1234) begin errors++; $display("FAIL prio_sp: got %h expected 1234", rf(4)); end
        checks++;
        if (rf(6) !== 64'h55) begin errors++; $display("FAIL prio_dst1: got %h expected 55", rf(6)); end
        // Same index on both ports: dst0 wins. Plain SP +8 with no SP write.
        wbif.wb_sp_adj = 2'b01;
        wbif.wb_dst0_idx = 4'd7; wbif.wb_dst0_data = 64'h11;
        wbif.wb_dst1_idx = 4'd7; wbif.wb_dst1_data = 64'h22;
        tick();
        checks++;
        if (rf(7) !== 64'h11) begin errors++; $display("FAIL prio_equal_idx: got %h expected 11", rf(7)); end
        checks++;
        if (rf(4) !== 64'h123C) begin errors++; $display("FAIL sp_inc: got %h expected 123c", rf(4)); end
        // Disabled ports write nothing; sp_adj=11 is a no-op.
        wbif.wb_sp_adj = 2'b11;
        wbif.wb_dst0_en = 1'b0; wbif.wb_dst0_idx = 4'd5; wbif.wb_dst0_data = 64'hFF;
        wbif.wb_dst1_en = 1'b0; wbif.wb_dst1_idx = 4'd5; wbif.wb_dst1_data = 64'hEE;
        tick();
        clear_inputs();
        checks++;
        if (rf(5) !== 64'd0) begin errors++; $display("FAIL disabled_write: got %h expected 0", rf(5)); end
        checks++;
        if (rf(4) !== 64'h123C) begin errors++; $display("FAIL sp_noop: got %h expected 123c", rf(4)); end
        checks++;
        if (retire_cnt !== 32'd3) begin errors++; $display("FAIL prio_cnt: got %0d expected 3", retire_cnt); end
    endtask

    task automatic test_store_wait();
        apply_reset();
        wbif.wb_valid = 1'b1; wbif.wb_sp_adj = 2'b10; wbif.wb_store = 1'b1;
        tick();
        checks++;
        if (rf(4) !== 64'h7FFF_EFF8) begin errors++; $display("FAIL store_sp: got %h expected 7fffeff8", rf(4)); end
        // A bundle held during the wait must not be taken.
        clear_inputs();
        wbif.wb_valid = 1'b1;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd8; wbif.wb_dst0_data = 64'h99;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wbif.store_req !== 1'b1 || wbif.wb_ready !== 1'b0) begin
                errors++;
                $display("FAIL store_wait_cyc%0d: got store_req=%b ready=%b expected 1 0", k, wbif.store_req, wbif.wb_ready);
            end
            if (k < 2) tick();
        end
        wbif.store_ack = 1'b1;
        tick();
        wbif.store_ack = 1'b0;
        wbif.wb_valid = 1'b0;
        checks++;
        if (wbif.store_req !== 1'b0 || wbif.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_release: got store_req=%b ready=%b expected 0 1", wbif.store_req, wbif.wb_ready);
        end
        checks++;
        if (rf(8) !== 64'd0 || retire_cnt !== 32'd1) begin
            errors++;
            $display("FAIL store_held_bundle: got rf8=%h cnt=%0d expected 0 1", rf(8), retire_cnt);
        end
        // Ack already high when store_req rises: exactly one cycle of STORE_WAIT.
        wbif.wb_valid = 1'b1; wbif.wb_store = 1'b1; wbif.store_ack = 1'b1;
        tick();
        wbif.wb_valid = 1'b0; wbif.wb_store = 1'b0;
        checks++;
        if (wbif.store_req !== 1'b1) begin errors++; $display("FAIL fast_ack_req: got %b expected 1", wbif.store_req); end
        tick();
        wbif.store_ack = 1'b0;
        checks++;
        if (wbif.store_req !== 1'b0 || wbif.wb_ready !== 1'b1 || retire_cnt !== 32'd2) begin
            errors++;
            $display("FAIL fast_ack_done: got store_req=%b ready=%b cnt=%0d expected 0 1 2", wbif.store_req, wbif.wb_ready, retire_cnt);
        end
    endtask

    task automatic test_store_end();
        apply_reset();
        wbif.wb_valid = 1'b1; wbif.wb_store = 1'b1; wbif.wb_end = 1'b1;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd5; wbif.wb_dst0_data = 64'hABC;
        tick();
        clear_inputs();
        checks++;
        if (rf(5) !== 64'hABC || wbif.store_req !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL store_end_wait: got rf5=%h store_req=%b halted=%b expected abc 1 0", rf(5), wbif.store_req, halted);
        end
        wbif.store_ack = 1'b1;
        tick();
        wbif.store_ack = 1'b0;
        checks++;
        if (halted !== 1'b1 || wbif.store_req !== 1'b0) begin
            errors++;
            $display("FAIL store_end_halt: got halted=%b store_req=%b expected 1 0", halted, wbif.store_req);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        wbif.wb_valid = 1'b1; wbif.wb_end = 1'b1;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd3; wbif.wb_dst0_data = 64'd9;
        tick();
        wbif.wb_end = 1'b0; wbif.wb_dst0_data = 64'h77; wbif.wb_store = 1'b1;
        checks++;
        if (rf(3) !== 64'd9 || halted !== 1'b1 || wbif.wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: got rf3=%h halted=%b ready=%b expected 9 1 0", rf(3), halted, wbif.wb_ready);
        end
        wbif.store_ack = 1'b1;
        repeat (3) tick();
        clear_inputs();
        checks++;
        if (rf(3) !== 64'd9 || retire_cnt !== 32'd1 || halted !== 1'b1 || wbif.store_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: got rf3=%h cnt=%0d halted=%b store_req=%b expected 9 1 1 0",
                     rf(3), retire_cnt, halted, wbif.store_req);
        end
    endtask

    task automatic test_reset_in_store_wait();
        apply_reset();
        wbif.wb_valid = 1'b1; wbif.wb_store = 1'b1; wbif.wb_sp_adj = 2'b01;
        wbif.wb_dst0_en = 1'b1; wbif.wb_dst0_idx = 4'd1; wbif.wb_dst0_data = 64'h42;
        tick();
        clear_inputs();
        checks++;
        if (wbif.store_req !== 1'b1 || rf(1) !== 64'h42) begin
            errors++;
            $display("FAIL pre_reset: got store_req=%b rf1=%h expected 1 42", wbif.store_req, rf(1));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wbif.store_req !== 1'b0 || wbif.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_state: got store_req=%b ready=%b expected 0 1", wbif.store_req, wbif.wb_ready);
        end
        checks++;
        if (rf(1) !== 64'd0 || rf(4) !== SP_RST || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_regs: got rf1=%h rf4=%h cnt=%0d expected 0 %h 0", rf(1), rf(4), retire_cnt, SP_RST);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_dual_write();
        test_priority();
        test_store_wait();
        test_store_end();
        test_halt();
        test_reset_in_store_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_writeback_rf.md
Name: mod_writeback_rf

Overview:
- Clocked, parametrised writeback stage that owns the architectural register file.
- Retires one EX/WB bundle per handshake, with two destination write ports (primary plus secondary, e.g. the high half of a multiply) and an implicit stack-pointer adjust.
- Stalls retirement until the memory stage acknowledges a pending store.
- Halts cleanly at end of program.
- Sits after the execute stage; feeds the register file to decode/register-read.

Parameters:
- NUM_REGS, 16, number of architectural registers
- DATA_W, 64, register width in bits
- IDX_W, 4, register index width; must satisfy 2**IDX_W >= NUM_REGS
- SP_IDX, 4, index of the stack-pointer register
- SP_STEP, 8, byte step applied by a stack-pointer adjust
- SP_RESET, 64'h0000_0000_7FFF_F000, reset value of the stack pointer
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  EX/WB bundle valid
- wb_ready  out  1  stage can accept a bundle
- wb_dst0_en  in  1  primary write enable
- wb_dst0_idx  in  IDX_W  primary destination index
- wb_dst0_data  in  DATA_W  primary write data
- wb_dst1_en  in  1  secondary write enable
- wb_dst1_idx  in  IDX_W  secondary destination index
- wb_dst1_data  in  DATA_W  secondary write data
- wb_sp_adj  in  2  00 none, 01 +SP_STEP, 10 -SP_STEP, 11 none
- wb_store  in  1  bundle is a store; retirement waits for store_ack
- wb_end  in  1  last instruction of the program
- store_ack  in  1  memory stage has completed the store
- store_req  out  1  store outstanding
- regfile  out  NUM_REGS*DATA_W  flattened register file; register i occupies bits [i*DATA_W +: DATA_W]
- halted  out  1  program ended; no further bundles are accepted
- retire_cnt  out  CNT_W  count of accepted bundles

Behaviour:
- Reset values (asynchronous): all registers 0 except register SP_IDX = SP_RESET; store_req=0; halted=0; retire_cnt=0; state=RUN.
- Reset asserted mid-operation: any outstanding store_req is dropped and the stage returns to RUN immediately.
- Accept = wb_valid && wb_ready. Register updates become visible in regfile on the accepting edge (latency 1).
- Write ordering within one accept, lowest to highest priority:
  - stack-pointer adjust (wraps modulo 2**DATA_W)
  - dst1
  - dst0
  - So a POP into SP_IDX leaves the popped value in SP_IDX, and dst0 overrides dst1 on an equal index.
- An index >= NUM_REGS is ignored for that port only.
- An enable of 0 means no write from that port, regardless of its index.
- retire_cnt increments by 1 per accept and wraps at 2**CNT_W.
- States:
  - RUN: wb_ready=1.
    - Accept with wb_store=1 -> STORE_WAIT; store_req=1 from the next cycle.
    - Accept with wb_store=0 and wb_end=1 -> HALT.
    - Otherwise stay in RUN.
  - STORE_WAIT: wb_ready=0; store_req=1.
    - store_ack=1 -> store_req=0 the next cycle. Go to HALT if the stored bundle carried wb_end, else RUN.
    - store_ack in RUN or HALT is ignored.
  - HALT: wb_ready=0, halted=1; only reset leaves this state.
- wb_store and wb_end set together: the register writes commit at accept, the stage waits for store_ack, then halts.
- store_ack arriving on the same cycle store_req first rises is honoured. Minimum STORE_WAIT residency is 1 cycle.
- Bundles presented while wb_ready=0 are ignored; the upstream stage holds them until accepted.

Optional Feature:
- Macro WB_BYPASS_EN, when defined:
  - Adds ports byp_idx (in, IDX_W) and byp_data (out, DATA_W).
  - byp_data is combinational. It returns the value register byp_idx will hold after the current cycle's accept, using the same port priority as the register writes, so decode sees same-cycle writebacks.
  - Returns the current regfile value when there is no accept or no matching write.
- When undefined: neither port exists; consumers read regfile, which reflects a write one cycle after the accept.

Test Plan:
- Reset release -> regfile[4]=64'h7FFF_F000, all other registers 0, wb_ready=1, retire_cnt=0.
- Accept dst0=(idx 0, 5), dst1=(idx 2, 7) -> the next cycle regfile[0]=5, regfile[2]=7, retire_cnt=1.
- Accept wb_sp_adj=01 with dst0=(idx 4, 64'h1234) -> regfile[4]=64'h1234 (dst0 overrides the stack-pointer adjust).
- Accept wb_sp_adj=10 with wb_store=1; hold store_ack low for 3 cycles -> regfile[4]=64'h7FFF_EFF8; store_req=1 and wb_ready=0 for 3 cycles; after store_ack, wb_ready=1 the next cycle.
- Accept wb_end=1 with dst0=(idx 3, 9) -> regfile[3]=9, halted=1; further wb_valid is ignored and retire_cnt does not change.
- Assert reset during STORE_WAIT -> store_req=0 and state RUN immediately; registers return to reset values.
